// File: rtl/hack_cpu_stall.sv
// ---------------------------------------------------------------------------
// hack_cpu_stall
//   Hack CPU core with a configurable data width, a data-memory req/ready
//   handshake that inserts wait states, signed LT/EQ/GT jump decode and a
//   retired-instruction counter. The instruction ROM is combinational and
//   addressed by pc. The data RAM/MMIO sits behind addressM/outM/inM.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   instruction  in   ROM word at address pc (valid in the same cycle)
//   inM          in   RAM read data, sampled when mem_req && mem_ready
//   mem_ready    in   RAM accepts or completes the current access this cycle
//   outM         out  ALU result (combinational), also the RAM write data
//   addressM     out  RAM address, which is the low bits of A
//   mem_req      out  the current C-instruction reads M or writes M
//   writeM       out  the current C-instruction writes M
//   pc           out  address of the current instruction
//   stall        out  mem_req && !mem_ready
//   illegal      out  sticky flag for opcodes 100/101/110 in instr[15:13]
//   retired      out  number of retired instructions, wraps
// ---------------------------------------------------------------------------
module hack_cpu_stall #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int PC_W   = 15,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instruction,
    input  logic [DATA_W-1:0] inM,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] outM,
    output logic [ADDR_W-1:0] addressM,
    output logic              mem_req,
    output logic              writeM,
    output logic [PC_W-1:0]   pc,
    output logic              stall,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic {
        S_EXEC = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state_q;

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  ret_q, ret_d;
    logic              ill_q, ill_d;

    // ---------------- decode ----------------
    logic       is_a_instr;
    logic       is_c_instr;
    logic       is_bad_instr;
    logic       use_m;
    logic [5:0] alu_ctrl;
    logic       dest_a, dest_d, dest_m;
    logic [2:0] jump_bits;

    assign is_a_instr   = ~instruction[15];
    assign is_c_instr   = &instruction[15:13];
    assign is_bad_instr = instruction[15] & ~is_c_instr;
    assign use_m        = instruction[12];
    assign alu_ctrl     = instruction[11:6];
    assign dest_a       = instruction[5];
    assign dest_d       = instruction[4];
    assign dest_m       = instruction[3];
    assign jump_bits    = instruction[2:0];

    // ---------------- ALU ----------------
    logic [DATA_W-1:0] alu_x, alu_y, alu_out;
    logic              alu_zr, alu_ng;

    always_comb begin
        alu_x = d_q;
        if (alu_ctrl[5]) alu_x = '0;
        if (alu_ctrl[4]) alu_x = ~alu_x;
        alu_y = use_m ? inM : a_q;
        if (alu_ctrl[3]) alu_y = '0;
        if (alu_ctrl[2]) alu_y = ~alu_y;
        alu_out = alu_ctrl[1] ? (alu_x + alu_y) : (alu_x & alu_y);
        if (alu_ctrl[0]) alu_out = ~alu_out;
    end

    assign alu_zr = (alu_out == '0);
    assign alu_ng = alu_out[DATA_W-1];

    logic jump_taken;
    assign jump_taken = (jump_bits[2] & alu_ng) |
                        (jump_bits[1] & alu_zr) |
                        (jump_bits[0] & ~alu_ng & ~alu_zr);

    // ---------------- memory handshake ----------------
    logic mem_req_w;
    logic retire_en;

    assign mem_req_w = is_c_instr & (use_m | dest_m);

    // In WAIT the same instruction is still presented, so the access
    // completes (and the instruction retires) on the first mem_ready.
    assign retire_en = (state_q == S_WAIT) ? mem_ready : ~(mem_req_w & ~mem_ready);

    // ---------------- next architectural state ----------------
    always_comb begin
        a_d   = a_q;
        d_d   = d_q;
        pc_d  = pc_q;
        ret_d = ret_q;
        ill_d = ill_q;
        if (retire_en) begin
            ret_d = ret_q + CNT_W'(1);
            pc_d  = pc_q + PC_W'(1);
            if (is_a_instr) begin
                a_d = {{(DATA_W-15){1'b0}}, instruction[14:0]};
            end else if (is_c_instr) begin
                // Jump target uses A as it was before this instruction.
                if (jump_taken) pc_d = a_q[PC_W-1:0];
                if (dest_a)     a_d  = alu_out;
                if (dest_d)     d_d  = alu_out;
            end else begin
                ill_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EXEC;
            a_q     <= '0;
            d_q     <= '0;
            pc_q    <= '0;
            ret_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            a_q   <= a_d;
            d_q   <= d_d;
            pc_q  <= pc_d;
            ret_q <= ret_d;
            ill_q <= ill_d;
            case (state_q)
                S_EXEC:  state_q <= (mem_req_w && !mem_ready) ? S_WAIT : S_EXEC;
                S_WAIT:  state_q <= mem_ready ? S_EXEC : S_WAIT;
                default: state_q <= S_EXEC;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign outM     = alu_out;
    assign addressM = a_q[ADDR_W-1:0];
    assign mem_req  = mem_req_w;
    assign writeM   = is_c_instr & dest_m;
    assign pc       = pc_q;
    assign stall    = mem_req_w & ~mem_ready;
    assign illegal  = ill_q;
    assign retired  = ret_q;

endmodule

// File: tb/tb_hack_cpu_stall.sv
// ---------------------------------------------------------------------------
// tb_hack_cpu_stall
//   Directed programs followed by a randomized program with random wait
//   states. An instruction-level Hack model predicts pc, retired, illegal,
//   the memory request and the ALU result for every cycle. A second instance
//   with DATA_W=32 checks A-instruction zero extension.
// ---------------------------------------------------------------------------
module tb_hack_cpu_stall;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instruction;
    logic [15:0] inM;
    logic        mem_ready;
    logic [15:0] outM;
    logic [14:0] addressM;
    logic        mem_req, writeM, stall, illegal;
    logic [14:0] pc;
    logic [31:0] retired;

    // 32-bit data path instance
    logic [15:0] instruction32;
    logic [31:0] inM32;
    logic        mem_ready32;
    logic [31:0] outM32;
    logic [14:0] addressM32;
    logic        mem_req32, writeM32, stall32, illegal32;
    logic [14:0] pc32;
    logic [31:0] retired32;

    logic [15:0] rom   [0:63];
    logic [15:0] rom32 [0:3];
    logic [15:0] ram   [0:32767];

    always #5 clk = ~clk;

    assign instruction   = rom[pc[5:0]];
    assign instruction32 = rom32[pc32[1:0]];
    assign inM32         = 32'h0;
    assign mem_ready32   = 1'b1;

    hack_cpu_stall u_dut (
        .clk(clk), .rst(rst), .instruction(instruction), .inM(inM),
        .mem_ready(mem_ready), .outM(outM), .addressM(addressM),
        .mem_req(mem_req), .writeM(writeM), .pc(pc), .stall(stall),
        .illegal(illegal), .retired(retired)
    );

    hack_cpu_stall #(.DATA_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .instruction(instruction32), .inM(inM32),
        .mem_ready(mem_ready32), .outM(outM32), .addressM(addressM32),
        .mem_req(mem_req32), .writeM(writeM32), .pc(pc32), .stall(stall32),
        .illegal(illegal32), .retired(retired32)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Capture of writes the DUT actually commits to RAM
    int          wr_cnt = 0;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;
    always @(posedge clk) begin
        if (!rst && mem_req && writeM && mem_ready) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= addressM;
            wr_data <= outM;
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] m_a, m_d;
    logic [14:0] m_pc;
    logic [31:0] m_ret;
    logic        m_ill;
    int          lo_cnt = 0;       // forced not-ready cycles for the next access
    bit          rand_ready = 1'b0;
    int          stall_seen = 0;

    function automatic logic [15:0] alu(input logic [5:0] c, input logic [15:0] x,
                                        input logic [15:0] y);
        logic [15:0] xx, yy, r;
        xx = c[5] ? 16'h0 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0 : y;
        if (c[2]) yy = ~yy;
        r = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) r = ~r;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0; m_ret = 32'h0; m_ill = 1'b0;
        lo_cnt = 0;
    endtask

    // One clock cycle: predict, drive, compare, then advance the model if
    // the instruction retires on this edge.
    task automatic step();
        logic [15:0] ins, y, res;
        logic        is_a, is_c, exp_req, rdy, lt, eq, gt, take;
        ins     = rom[m_pc[5:0]];
        is_a    = !ins[15];
        is_c    = (ins[15:13] == 3'b111);
        exp_req = is_c && (ins[12] || ins[3]);
        chk("pc", 64'(pc), 64'(m_pc));
        chk("retired", 64'(retired), 64'(m_ret));
        chk("illegal", 64'(illegal), 64'(m_ill));
        if (exp_req) begin
            if (lo_cnt > 0) begin
                rdy = 1'b0;
                lo_cnt--;
            end else if (rand_ready) begin
                rdy = ($urandom_range(0, 2) != 0);
            end else begin
                rdy = 1'b1;
            end
        end else begin
            rdy = 1'($urandom_range(0, 1));
        end
        mem_ready = rdy;
        inM = ram[addressM];
        y   = ins[12] ? ram[m_a[14:0]] : m_a;
        res = alu(ins[11:6], m_d, y);
        #1;
        chk("mem_req", 64'(mem_req), 64'(exp_req));
        chk("stall", 64'(stall), 64'(exp_req && !rdy));
        if (exp_req) begin
            chk("addressM", 64'(addressM), 64'(m_a[14:0]));
            chk("writeM", 64'(writeM), 64'(ins[3]));
        end
        if (is_c) chk("outM", 64'(outM), 64'(res));
        if (stall) stall_seen++;
        @(posedge clk);
        if (!(exp_req && !rdy)) begin
            $display("[TB] retire pc=%0d instr=0x%04h", m_pc, ins);
            if (is_a) begin
                m_a  = {1'b0, ins[14:0]};
                m_pc = m_pc + 15'd1;
            end else if (is_c) begin
                lt   = ($signed(res) < 0);
                eq   = (res == 16'h0);
                gt   = !lt && !eq;
                take = (ins[2] && lt) || (ins[1] && eq) || (ins[0] && gt);
                if (ins[3]) ram[m_a[14:0]] = res;
                m_pc = take ? m_a[14:0] : m_pc + 15'd1;
                if (ins[4]) m_d = res;
                if (ins[5]) m_a = res;
            end else begin
                m_ill = 1'b1;
                m_pc  = m_pc + 15'd1;
            end
            m_ret = m_ret + 32'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        int w0, s0;
        logic [31:0] v;
        rst = 1'b1;
        mem_ready = 1'b0;
        inM = 16'h0;
        for (int i = 0; i < 32768; i++) ram[i] = 16'($urandom);
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
        ram[15'h7FFF] = 16'hFFFF;
        // directed program
        rom[0]  = 16'h0005; rom[1]  = 16'hEC10;             // @5; D=A
        rom[2]  = 16'h0007; rom[3]  = 16'hE7C8;             // @7; M=D+1
        rom[4]  = 16'hEE90; rom[5]  = 16'h0014; rom[6]  = 16'hE304; // D=-1; @20; D;JLT
        rom[20] = 16'hEA90; rom[21] = 16'h001E; rom[22] = 16'hE302; // D=0; @30; D;JEQ
        rom[30] = 16'hEFD0; rom[31] = 16'h0028; rom[32] = 16'hE301; // D=1; @40; D;JGT
        rom[40] = 16'hE304;                                 // D;JLT (not taken)
        rom[41] = 16'h7FFF; rom[42] = 16'hFC10; rom[43] = 16'hE300; // @7FFF; D=M; D
        rom[44] = 16'hA000; rom[45] = 16'h0000;             // illegal; @0
        rom[46] = 16'h0007; rom[47] = 16'hE7C8;             // @7; M=D+1
        rom32[0] = 16'h7FFF; rom32[1] = 16'hEC10; rom32[2] = 16'hE300; rom32[3] = 16'hE300;

        // Reset state
        @(negedge clk);
        do_reset();
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_retired", 64'(retired), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);

        // T1: @5; D=A, plus 32-bit zero extension
        step();
        chk("w32_A_zext", 64'(outM32), 64'h0000_7FFF);
        step();
        chk("t1_pc", 64'(pc), 64'd2);
        chk("t1_retired", 64'(retired), 64'd2);
        chk("w32_D_zext", 64'(outM32), 64'h0000_7FFF);

        // T2: M=D+1 with three not-ready cycles
        step();
        w0 = wr_cnt; s0 = stall_seen; lo_cnt = 3;
        repeat (4) step();
        chk("t2_stalls", 64'(stall_seen - s0), 64'd3);
        chk("t2_writes", 64'(wr_cnt - w0), 64'd1);
        chk("t2_wr_addr", 64'(wr_addr), 64'd7);
        chk("t2_wr_data", 64'(wr_data), 64'd6);
        chk("t2_pc", 64'(pc), 64'd4);
        chk("t2_retired", 64'(retired), 64'd4);

        // T3: jumps
        repeat (3) step();
        chk("t3_jlt_pc", 64'(pc), 64'd20);
        repeat (3) step();
        chk("t3_jeq_pc", 64'(pc), 64'd30);
        repeat (3) step();
        chk("t3_jgt_pc", 64'(pc), 64'd40);
        step();
        chk("t3_jlt_nt_pc", 64'(pc), 64'd41);

        // T4: D=M with inM=0xFFFF
        repeat (2) step();
        chk("t4_D_from_M", 64'(outM), 64'hFFFF);
        step();

        // T5: illegal opcode is sticky
        step();
        chk("t5_illegal", 64'(illegal), 64'd1);
        chk("t5_pc", 64'(pc), 64'd45);
        step();
        chk("t5_sticky", 64'(illegal), 64'd1);

        // T6: reset while waiting on memory
        step();
        lo_cnt = 10;
        repeat (3) step();
        chk("t6_waiting_pc", 64'(pc), 64'd47);
        do_reset();
        chk("t6_pc", 64'(pc), 64'd0);
        chk("t6_retired", 64'(retired), 64'd0);
        chk("t6_illegal", 64'(illegal), 64'd0);
        #1;
        chk("t6_mem_req", 64'(mem_req), 64'd0);
        @(negedge clk);

        // Randomized program with random wait states
        for (int i = 0; i < 64; i++) begin
            v = $urandom_range(0, 99);
            if (v < 40) begin
                if ($urandom_range(0, 3) == 0) rom[i] = {1'b0, 15'($urandom)};
                else                           rom[i] = {1'b0, 15'($urandom_range(0, 63))};
            end else if (v < 97) begin
                rom[i] = {3'b111, 13'($urandom)};
            end else begin
                rom[i] = {1'b1, 2'($urandom_range(0, 2)), 13'($urandom)};
            end
        end
        rand_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
